// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC types, sizes and ring-pointer helper
// Purpose: flit format, default VC count/depth and the wrap_inc helper used by
//          every ring buffer in the router.
// Ports:   none (package).
package noc_params;

  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 4;
  // Keep at least one index bit so a single-VC build still has a legal port.
  localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int FLIT_W   = 32;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t                  ftype;
    logic [VC_SIZE-1:0]          vc_id;
    logic [FLIT_W-3-VC_SIZE:0]   payload;
  } flit_t;

  // Ring-pointer increment for depths that need not be a power of two.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// rtl/vc_input_buffer_if.sv - enqueue/dequeue/status bundle of the VC input buffer
// Purpose: groups the link-side write port, the router-side read port, the
//          per-VC status vectors, credit return and sticky error flags.
// Ports:   none; modport slave is the buffer, modport master is its user.
interface vc_input_buffer_if
  import noc_params::*;
#(
  parameter int NUM_VC = VC_NUM,
  parameter int DEPTH  = VC_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) ();

  logic                          write_i;
  logic [VC_SIZE-1:0]            write_vc_i;
  flit_t                         data_i;
  logic                          read_i;
  logic [VC_SIZE-1:0]            read_vc_i;
  flit_t                         data_o;
  logic [NUM_VC-1:0]             is_full_o;
  logic [NUM_VC-1:0]             is_empty_o;
  logic [NUM_VC-1:0][CNT_W-1:0]  occupancy_o;
  logic                          credit_o;
  logic [VC_SIZE-1:0]            credit_vc_o;
  logic                          overflow_o;
  logic                          underflow_o;
  logic                          clear_err_i;

  modport slave (
    input  write_i, write_vc_i, data_i, read_i, read_vc_i, clear_err_i,
    output data_o, is_full_o, is_empty_o, occupancy_o, credit_o, credit_vc_o,
           overflow_o, underflow_o
  );

  modport master (
    output write_i, write_vc_i, data_i, read_i, read_vc_i, clear_err_i,
    input  data_o, is_full_o, is_empty_o, occupancy_o, credit_o, credit_vc_o,
           overflow_o, underflow_o
  );

endinterface

// File: rtl/vc_fifo_ctrl.sv
// rtl/vc_fifo_ctrl.sv - pointer and count bookkeeping for one virtual channel
// Purpose: ring pointers and flit count of a single VC FIFO; storage lives in
//          the parent.
// Ports:   clk, rst (async, active low); push_i/pop_i already-legal requests;
//          wr_ptr_o/rd_ptr_o ring pointers; full_o/empty_o/count_o status.
module vc_fifo_ctrl
  import noc_params::*;
#(
  parameter int DEPTH  = VC_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
    if (pop_i)  rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
    // Parent guarantees push only when not full and pop only when not empty,
    // so the count stays within 0..DEPTH.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - per-port multi-VC input buffer with credit return
// Purpose: NUM_VC independent FWFT FIFOs sharing one flit memory; drops
//          overflowing writes and empty reads, flagging them in sticky bits,
//          and returns one registered credit per legal dequeue.
// Ports:   clk, rst (async, active low); bus (slave) carries write/read
//          requests, head data, per-VC status, credit and error flags.
module vc_input_buffer
  import noc_params::*;
#(
  parameter int NUM_VC = VC_NUM,
  parameter int DEPTH  = VC_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  vc_input_buffer_if.slave   bus
);

  logic [NUM_VC-1:0]            push_vec, pop_vec;
  logic [NUM_VC-1:0]            full_vec, empty_vec;
  logic [NUM_VC-1:0][PTR_W-1:0] wr_ptr, rd_ptr;
  logic [NUM_VC-1:0][CNT_W-1:0] count;

  logic write_legal, read_legal;
  logic overflow_evt, underflow_evt;

  logic               credit_q, credit_d;
  logic [VC_SIZE-1:0] credit_vc_q, credit_vc_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  flit_t mem [NUM_VC][DEPTH];

  // An out-of-range VC index matches no channel, so it decodes as illegal.
  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_vec[v] = bus.write_i && (int'(bus.write_vc_i) == v) && !full_vec[v];
      pop_vec[v]  = bus.read_i  && (int'(bus.read_vc_i)  == v) && !empty_vec[v];
    end
  end

  assign write_legal   = |push_vec;
  assign read_legal    = |pop_vec;
  assign overflow_evt  = bus.write_i && !write_legal;
  assign underflow_evt = bus.read_i  && !read_legal;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .push_i   (push_vec[g]),
      .pop_i    (pop_vec[g]),
      .wr_ptr_o (wr_ptr[g]),
      .rd_ptr_o (rd_ptr[g]),
      .full_o   (full_vec[g]),
      .empty_o  (empty_vec[g]),
      .count_o  (count[g])
    );
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vec[v]) mem[v][wr_ptr[v]] <= bus.data_i;
    end
  end

  // First-word-fall-through head of the selected VC.
  always_comb begin
    bus.data_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (int'(bus.read_vc_i) == v) bus.data_o = mem[v][rd_ptr[v]];
    end
  end

  always_comb begin
    credit_d    = read_legal;
    credit_vc_d = read_legal ? bus.read_vc_i : credit_vc_q;
    // A fresh error in the same cycle as a clear keeps the flag set.
    overflow_d  = overflow_evt  || (overflow_q  && !bus.clear_err_i);
    underflow_d = underflow_evt || (underflow_q && !bus.clear_err_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q    <= 1'b0;
      credit_vc_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      credit_vc_q <= credit_vc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.is_full_o   = full_vec;
  assign bus.is_empty_o  = empty_vec;
  assign bus.occupancy_o = count;
  assign bus.credit_o    = credit_q;
  assign bus.credit_vc_o = credit_vc_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - self-checking bench for vc_input_buffer
module tb_vc_input_buffer;
  import noc_params::*;

  localparam int NV = 4;
  localparam int DP = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: one queue per VC plus expected credit and sticky flags.
  logic [31:0] mq [NV][$];
  bit          m_credit;
  int          m_credit_vc;
  bit          m_ovf;
  bit          m_unf;

  vc_input_buffer_if #(.NUM_VC(NV), .DEPTH(DP)) bus ();

  vc_input_buffer #(.NUM_VC(NV), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.write_i     = 1'b0;
    bus.write_vc_i  = '0;
    bus.data_i      = '0;
    bus.read_i      = 1'b0;
    bus.read_vc_i   = '0;
    bus.clear_err_i = 1'b0;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mq[v].delete();
    m_credit    = 1'b0;
    m_credit_vc = 0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
  endtask

  task automatic drive(input bit w, input int wvc, input logic [31:0] wd,
                       input bit r, input int rvc, input bit clr);
    bus.write_i     = w;
    bus.write_vc_i  = VC_SIZE'(wvc);
    bus.data_i      = flit_t'(wd);
    bus.read_i      = r;
    bus.read_vc_i   = VC_SIZE'(rvc);
    bus.clear_err_i = clr;
  endtask

  // One clock: sample the driven request, advance the model with the rules
  // of the buffer, then return inputs to idle 1 time unit after the edge.
  task automatic tick();
    bit w, r, clr, wl, rl;
    int wvc, rvc;
    logic [31:0] wd;
    w   = bus.write_i;
    wvc = int'(bus.write_vc_i);
    wd  = bus.data_i;
    r   = bus.read_i;
    rvc = int'(bus.read_vc_i);
    clr = bus.clear_err_i;
    wl  = w && (wvc < NV) && (mq[wvc].size() < DP);
    rl  = r && (rvc < NV) && (mq[rvc].size() > 0);
    @(posedge clk);
    if (rl) void'(mq[rvc].pop_front());
    if (wl) mq[wvc].push_back(wd);
    m_credit = rl;
    if (rl) m_credit_vc = rvc;
    m_ovf = (w && !wl) || (m_ovf && !clr);
    m_unf = (r && !rl) || (m_unf && !clr);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.is_empty_o !== 4'b1111 || bus.is_full_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags empty=%b full=%b required empty=1111 full=0000", bus.is_empty_o, bus.is_full_o);
    end
    checks++;
    if (bus.credit_o !== 1'b0 || bus.credit_vc_o !== '0 || bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs credit=%b vc=%0d ovf=%b unf=%b required all 0", bus.credit_o, bus.credit_vc_o, bus.overflow_o, bus.underflow_o);
    end
    checks++;
    if (bus.occupancy_o !== '0) begin
      errors++;
      $display("FAIL reset_occ got %h required 0", bus.occupancy_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DP; i++) begin
      drive(1, 0, $urandom, 0, 0, 0);
      tick();
    end
    checks++;
    if (bus.is_full_o[0] !== 1'b1 || int'(bus.occupancy_o[0]) !== DP) begin
      errors++;
      $display("FAIL fill_vc0 full=%b occ=%0d required full=1 occ=%0d", bus.is_full_o[0], bus.occupancy_o[0], DP);
    end
    checks++;
    if (bus.is_empty_o !== 4'b1110) begin
      errors++;
      $display("FAIL fill_others empty=%b required 1110", bus.is_empty_o);
    end
  endtask

  task automatic test_drain();
    logic [31:0] obs;
    for (int i = 0; i < DP; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      #1;
      obs = bus.data_o;
      checks++;
      if (obs !== mq[0][0]) begin
        errors++;
        $display("FAIL drain_data[%0d] got %h required %h", i, obs, mq[0][0]);
      end
      tick();
      checks++;
      if (bus.credit_o !== 1'b1 || int'(bus.credit_vc_o) !== 0) begin
        errors++;
        $display("FAIL drain_credit[%0d] credit=%b vc=%0d required 1/0", i, bus.credit_o, bus.credit_vc_o);
      end
    end
    tick();
    checks++;
    if (bus.credit_o !== 1'b0 || bus.is_empty_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL drain_end credit=%b empty0=%b required 0/1", bus.credit_o, bus.is_empty_o[0]);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DP; i++) begin
      drive(1, 1, $urandom, 0, 0, 0);
      tick();
    end
    drive(1, 1, $urandom, 1, 1, 0);
    tick();
    checks++;
    if (bus.overflow_o !== 1'b1 || int'(bus.occupancy_o[1]) !== 3) begin
      errors++;
      $display("FAIL full_rw ovf=%b occ1=%0d required 1/3", bus.overflow_o, bus.occupancy_o[1]);
    end
    checks++;
    if (bus.credit_o !== 1'b1 || int'(bus.credit_vc_o) !== 1) begin
      errors++;
      $display("FAIL full_rw_credit credit=%b vc=%0d required 1/1", bus.credit_o, bus.credit_vc_o);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    checks++;
    if (bus.overflow_o !== 1'b0 || bus.credit_o !== 1'b0 || int'(bus.credit_vc_o) !== 1) begin
      errors++;
      $display("FAIL clear_err ovf=%b credit=%b vc=%0d required 0/0/1", bus.overflow_o, bus.credit_o, bus.credit_vc_o);
    end
  endtask

  task automatic test_cross_vc();
    logic [31:0] obs;
    for (int i = 0; i < 2; i++) begin
      drive(1, 3, $urandom, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 2, $urandom, 1, 3, 0);
      tick();
    end
    checks++;
    if (int'(bus.occupancy_o[2]) !== 4 || bus.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL cross_vc2 occ=%0d ovf=%b required 4/1", bus.occupancy_o[2], bus.overflow_o);
    end
    checks++;
    if (int'(bus.occupancy_o[3]) !== 0 || bus.underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL cross_vc3 occ=%0d unf=%b required 0/1", bus.occupancy_o[3], bus.underflow_o);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    // Refill VC3 across its pointer wrap, then drain VC3 and VC2 in order.
    for (int i = 0; i < DP; i++) begin
      drive(1, 3, $urandom, 0, 0, 0);
      tick();
    end
    for (int vc = 3; vc >= 2; vc--) begin
      for (int i = 0; i < DP; i++) begin
        drive(0, 0, 0, 1, vc, 0);
        #1;
        obs = bus.data_o;
        checks++;
        if (obs !== mq[vc][0]) begin
          errors++;
          $display("FAIL wrap_data vc%0d[%0d] got %h required %h", vc, i, obs, mq[vc][0]);
        end
        tick();
      end
    end
    checks++;
    if (bus.is_empty_o[3:2] !== 2'b11 || bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end empty=%b ovf=%b unf=%b required 11/0/0", bus.is_empty_o[3:2], bus.overflow_o, bus.underflow_o);
    end
  endtask

  task automatic test_empty_rw();
    logic [31:0] wd, obs;
    wd = $urandom;
    drive(1, 0, wd, 1, 0, 0);
    tick();
    checks++;
    if (bus.underflow_o !== 1'b1 || int'(bus.occupancy_o[0]) !== 1 || bus.credit_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw unf=%b occ0=%0d credit=%b required 1/1/0", bus.underflow_o, bus.occupancy_o[0], bus.credit_o);
    end
    bus.read_vc_i = '0;
    #1;
    obs = bus.data_o;
    checks++;
    if (obs !== wd) begin
      errors++;
      $display("FAIL empty_rw_data got %h required %h", obs, wd);
    end
    drive(0, 0, 0, 1, 0, 1);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] obs;
    int rvc;
    for (int n = 0; n < 400; n++) begin
      rvc = $urandom_range(NV - 1);
      drive(($urandom_range(9) < 6), $urandom_range(NV - 1), $urandom,
            ($urandom_range(9) < 5), rvc, ($urandom_range(7) == 0));
      #1;
      if (mq[rvc].size() > 0) begin
        obs = bus.data_o;
        checks++;
        if (obs !== mq[rvc][0]) begin
          errors++;
          $display("FAIL rand_data cyc%0d vc%0d got %h required %h", n, rvc, obs, mq[rvc][0]);
        end
      end
      tick();
      for (int v = 0; v < NV; v++) begin
        checks++;
        if (int'(bus.occupancy_o[v]) !== mq[v].size() || bus.is_full_o[v] !== (mq[v].size() == DP) ||
            bus.is_empty_o[v] !== (mq[v].size() == 0)) begin
          errors++;
          $display("FAIL rand_state cyc%0d vc%0d occ=%0d full=%b empty=%b required occ=%0d", n, v,
                   bus.occupancy_o[v], bus.is_full_o[v], bus.is_empty_o[v], mq[v].size());
        end
      end
      checks++;
      if (bus.credit_o !== m_credit || int'(bus.credit_vc_o) !== m_credit_vc ||
          bus.overflow_o !== m_ovf || bus.underflow_o !== m_unf) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d credit=%b vc=%0d ovf=%b unf=%b required %b/%0d/%b/%b", n,
                 bus.credit_o, bus.credit_vc_o, bus.overflow_o, bus.underflow_o,
                 m_credit, m_credit_vc, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] wd, obs;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, $urandom, 0, 0, 0);
      tick();
    end
    drive(1, 0, $urandom, 1, 1, 0);
    tick();
    drive(1, 0, $urandom, 1, 3, 0);
    tick();
    drive(1, 2, $urandom, 1, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.is_empty_o !== 4'b1111 || bus.is_full_o !== 4'b0000 || bus.occupancy_o !== '0) begin
      errors++;
      $display("FAIL async_rst_state empty=%b full=%b occ=%h required 1111/0000/0", bus.is_empty_o, bus.is_full_o, bus.occupancy_o);
    end
    checks++;
    if (bus.credit_o !== 1'b0 || bus.credit_vc_o !== '0 || bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_outs credit=%b vc=%0d ovf=%b unf=%b required all 0", bus.credit_o, bus.credit_vc_o, bus.overflow_o, bus.underflow_o);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wd = $urandom;
    drive(1, 2, wd, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 2, 0);
    #1;
    obs = bus.data_o;
    checks++;
    if (obs !== wd) begin
      errors++;
      $display("FAIL post_rst_data got %h required %h", obs, wd);
    end
    tick();
    checks++;
    if (bus.credit_o !== 1'b1 || int'(bus.credit_vc_o) !== 2 || bus.is_empty_o !== 4'b1111) begin
      errors++;
      $display("FAIL post_rst_credit credit=%b vc=%0d empty=%b required 1/2/1111", bus.credit_o, bus.credit_vc_o, bus.is_empty_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_cross_vc();
    test_empty_rw();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
